// File: rtl/fx_seq.sv
// fx_seq: sequences (x*x+y)*x, x*y, x+y or a qNaN through a shared FP32 multiplier and adder
module fx_seq #(
  parameter int MUL_LAT = 5,
  parameter int ADD_LAT = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        start,
  input  logic [1:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_r,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_r
);
  localparam int LMAX = MUL_LAT > ADD_LAT ? MUL_LAT : ADD_LAT;
  localparam int CW = LMAX > 1 ? $clog2(LMAX) : 1;
  localparam logic [CW-1:0] MC = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] AC = CW'(ADD_LAT - 1);
  localparam logic [31:0] QNAN = 32'h7FC00000;
  typedef enum logic [2:0] {IDLE, MUL1, ADD, MUL2, FIN} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] x, y;
  logic chain;
  logic last;
  assign last = cnt == '0;
  // sequencer: each unit's operands are held for its full latency, the unit output is taken on the last cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      x      <= '0;
      y      <= '0;
      chain  <= 1'b0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      mul_a  <= '0;
      mul_b  <= '0;
      add_a  <= '0;
      add_b  <= '0;
    end else if (clk_en) begin
      case (state)
        IDLE: if (start) begin
          x     <= dataa;
          y     <= datab;
          chain <= n == 2'd0;
          busy  <= 1'b1;
          case (n)
            2'd0: begin state <= MUL1; cnt <= MC; mul_a <= dataa; mul_b <= dataa; end
            2'd1: begin state <= MUL2; cnt <= MC; mul_a <= dataa; mul_b <= datab; end
            2'd2: begin state <= ADD;  cnt <= AC; add_a <= dataa; add_b <= datab; end
            2'd3: begin state <= FIN;  result <= QNAN; done <= 1'b1; end
          endcase
        end
        MUL1: if (last) begin
          state <= ADD;
          cnt   <= AC;
          mul_a <= '0;
          mul_b <= '0;
          add_a <= mul_r;
          add_b <= y;
        end else cnt <= cnt - 1'b1;
        ADD: if (last) begin
          add_a <= '0;
          add_b <= '0;
          if (chain) begin
            state <= MUL2;
            cnt   <= MC;
            mul_a <= add_r;
            mul_b <= x;
          end else begin
            state  <= FIN;
            result <= add_r;
            done   <= 1'b1;
          end
        end else cnt <= cnt - 1'b1;
        MUL2: if (last) begin
          state  <= FIN;
          mul_a  <= '0;
          mul_b  <= '0;
          result <= mul_r;
          done   <= 1'b1;
        end else cnt <= cnt - 1'b1;
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fx_seq.md
FX_SEQ -- requirements
Module: fx_seq

Interface
REQ-001 SHALL have parameter MUL_LAT, default 5: fixed latency in cycles of the shared FP32 multiplier.
REQ-002 SHALL have parameter ADD_LAT, default 7: fixed latency in cycles of the shared FP32 adder.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; asynchronous and active-low.
REQ-005 SHALL have port clk_en  in  1  global stall; when low, all state and outputs hold.
REQ-006 SHALL have port start  in  1  custom-instruction start, one-cycle pulse.
REQ-007 SHALL have port n  in  2  operation select; sampled with start.
REQ-008 SHALL have port dataa  in  32  operand x (IEEE-754 single); sampled with start.
REQ-009 SHALL have port datab  in  32  operand y (IEEE-754 single); sampled with start.
REQ-010 SHALL have port result  out  32  registered result; valid while done=1, held afterwards.
REQ-011 SHALL have port done  out  1  one-cycle completion pulse.
REQ-012 SHALL have port busy  out  1  high from the cycle after an accepted start until the cycle done is high, inclusive.
REQ-013 SHALL have port mul_a, mul_b  out  32 each  registered multiplier operands.
REQ-014 SHALL have port mul_r  in  32  multiplier product, valid MUL_LAT cycles after operands are stable.
REQ-015 SHALL have port add_a, add_b  out  32 each  registered adder operands.
REQ-016 SHALL have port add_r  in  32  adder sum, valid ADD_LAT cycles after operands are stable.

Function
REQ-017 SHALL implement states IDLE, MUL1, ADD, MUL2, FIN; one-hot or binary encoding is permitted.
REQ-018 In IDLE with start=1 and clk_en=1, SHALL capture x, y and n, and load the cycle counter.
REQ-019 n=0: SHALL compute (x*x + y)*x as IDLE->MUL1(x,x)->ADD(t1,y)->MUL2(t2,x)->FIN.
REQ-020 n=1: SHALL compute x*y as IDLE->MUL2(x,y)->FIN.
REQ-021 n=2: SHALL compute x+y as IDLE->ADD(x,y)->FIN.
REQ-022 n=3: SHALL go IDLE->FIN directly with result 32'h7FC00000 (qNaN).
REQ-023 Each MUL state SHALL hold its operands stable on mul_a/mul_b for exactly MUL_LAT enabled cycles, then sample mul_r on the last of those cycles.
REQ-024 ADD SHALL hold its operands stable on add_a/add_b for exactly ADD_LAT enabled cycles, then sample add_r on the last of those cycles.
REQ-025 The cycle counter SHALL count down, load LAT-1 on state entry, and advance state when it reaches 0.
REQ-026 FIN SHALL last one cycle with done=1 and result updated, then return to IDLE.
REQ-027 Latency from the start edge to the done cycle, in enabled cycles, SHALL be: n=0: 2*MUL_LAT+ADD_LAT+1; n=1: MUL_LAT+1; n=2: ADD_LAT+1; n=3: 1.
REQ-028 start while busy=1 SHALL be ignored, with no effect on operands or sequence.
REQ-029 start in the FIN cycle SHALL be ignored; start is accepted again from the cycle after done.
REQ-030 clk_en=0 SHALL freeze state, counter, captured operands and all outputs, including holding done high if stalled in FIN.
REQ-031 mul_a, mul_b, add_a and add_b SHALL read 0 whenever their unit is not in use.
REQ-032 The block SHALL perform no floating-point arithmetic itself; all arithmetic is delegated to the shared units.

Reset
REQ-033 rst=0 SHALL immediately force IDLE, counter=0, result=0, done=0, busy=0, and all operand outputs to 0, regardless of clk.
REQ-034 Reset asserted mid-sequence SHALL abort the operation with no done pulse.
REQ-035 After reset is released, the next accepted start SHALL run a full, normal sequence.

Verification (bench supplies mul_r/add_r from behavioural FP32 models with MUL_LAT/ADD_LAT delay)
REQ-036 n=0, x=32'h40000000 (2.0), y=32'h3F800000 (1.0) -> done 18 cycles after start, result=32'h41200000 (10.0).
REQ-037 n=0, x=32'h43000000 (128.0), y=32'h40000000 (2.0) -> result=32'h4A000400 (2097408.0); mul_a=mul_b=x for exactly 5 cycles.
REQ-038 n=1, x=2.0, y=32'h40400000 (3.0) -> done 6 cycles after start, result=32'h40C00000; add_a=add_b=0 throughout.
REQ-039 n=2, x=1.0, y=1.0 -> done 8 cycles after start, result=32'h40000000; second start at cycle 3 is ignored.
REQ-040 n=3 -> done on the cycle after start, result=32'h7FC00000.
REQ-041 n=0 with clk_en low for 4 cycles during ADD -> done at cycle 22; rst low at cycle 10 of a second run -> no done, all outputs 0, next start completes normally.
